// File: rtl/gps_sm_pkg.sv
// Shared constants and helpers for sign-magnitude datapaths: field positions
// within a sign-magnitude word and an index-width helper.
package gps_sm_pkg;

    localparam int unsigned SM_MAG_LSB = 0;

    // Sign bit sits at the MSB of a sign-magnitude word of width w.
    function automatic int unsigned sm_sign_pos(input int unsigned w);
        return w - 1;
    endfunction

    // Magnitude occupies everything below the sign bit.
    function automatic int unsigned sm_mag_msb(input int unsigned w);
        return w - 2;
    endfunction

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned sm_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sm_to_twos.sv
// Combinational sign-magnitude to two's-complement conversion with sign
// extension; negative zero collapses to +0.
module sm_to_twos
    import gps_sm_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  sm_in,
    output logic [OUT_WIDTH-1:0] twos_c
);

    localparam int unsigned SIGN_POS  = sm_sign_pos(IN_WIDTH);
    localparam int unsigned MAG_MSB   = sm_mag_msb(IN_WIDTH);
    localparam int unsigned MAG_WIDTH = IN_WIDTH - 1;

    logic [MAG_WIDTH-1:0] mag;
    logic [OUT_WIDTH-1:0] mag_ext;

    assign mag     = sm_in[MAG_MSB:SM_MAG_LSB];
    assign mag_ext = OUT_WIDTH'(mag);

    // Zero magnitude takes the positive path so -0 never appears.
    assign twos_c = (sm_in[SIGN_POS] && (mag != '0)) ? -mag_ext : mag_ext;

endmodule

// File: rtl/sm_extend_arbiter.sv
// Round-robin arbiter feeding a shared two-stage sign-magnitude to
// two's-complement pipeline; results carry the index of their requester.
module sm_extend_arbiter
    import gps_sm_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned IN_WIDTH  = 3,
    parameter  int unsigned OUT_WIDTH = 16,
    localparam int unsigned IDX_WIDTH = sm_clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_value,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_value,
    output logic [IDX_WIDTH-1:0]        out_index
);

    logic [IDX_WIDTH-1:0] ptr_q,       ptr_d;
    logic                 s1_valid_q,  s1_valid_d;
    logic [IN_WIDTH-1:0]  s1_value_q,  s1_value_d;
    logic [IDX_WIDTH-1:0] s1_index_q,  s1_index_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_value_q, out_value_d;
    logic [IDX_WIDTH-1:0] out_index_q, out_index_d;

    logic                 grant_found;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IN_WIDTH-1:0]  grant_value;
    logic                 s2_free;
    logic                 s1_free;
    logic                 s1_adv;
    logic                 take;
    logic [OUT_WIDTH-1:0] conv_c;

    // Search from ptr upward, wrapping, for the first valid requester.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_value = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_WIDTH'(i) == grant_idx) begin
                grant_value = req_value[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    assign s2_free = !out_valid_q || out_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s2_free;
    assign take    = reset_n && grant_found && s1_free;

    // Grant is gated by reset so no requester sees a handshake while held.
    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    sm_to_twos #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sm_to_twos (
        .sm_in  (s1_value_q),
        .twos_c (conv_c)
    );

    // Next-state for the pointer and both pipeline stages.
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_value_d  = s1_value_q;
        s1_index_d  = s1_index_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_index_d = out_index_q;

        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_value_d = conv_c;
            out_index_d = s1_index_q;
            s1_valid_d  = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A new grant refills stage 1 in the same edge it drains.
        if (take) begin
            s1_valid_d = 1'b1;
            s1_value_d = grant_value;
            s1_index_d = grant_idx;
            ptr_d      = IDX_WIDTH'((32'(grant_idx) + 32'd1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_value_q  <= '0;
            s1_index_q  <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_value_q  <= s1_value_d;
            s1_index_q  <= s1_index_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_index = out_index_q;

endmodule
